fir_sample_feeder: RTL and testbench

//  Upstream stage of the per-channel ADC FIR filter. Edge-detects the ADC-interface sample strobe and

---
 rtl/fir_feeder_pkg.sv | 44 ++++
 rtl/feeder_fifo.sv | 94 +++++++++
 rtl/fir_sample_feeder.sv | 176 +++++++++++++++++
 tb/tb_fir_sample_feeder.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_feeder_pkg.sv
// Shared definitions for the FIR sample feeder: default sizes, clog2,
// FIFO entry layout and signed saturation limits.
package fir_feeder_pkg;

    // Ceiling log2 for sizing pointers and channel fields (value >= 1).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Default configuration of the feeder.
    localparam int DEF_NUM_CHAN   = 4;
    localparam int DEF_DATA_W     = 16;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_OVF_W      = 8;

    // Channel tag width for the default channel count.
    localparam int CH_W = clog2(DEF_NUM_CHAN);

    // FIFO entry layout is {chan, data}: data sits in the low bits,
    // the channel tag directly above it.
    localparam int ENTRY_DATA_LSB = 0;

    function automatic int entry_chan_lsb(input int data_w);
        return ENTRY_DATA_LSB + data_w;
    endfunction

    // Two's complement limits of a w-bit signed value.
    function automatic int sat_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int sat_min(input int w);
        return -(1 << (w - 1));
    endfunction

    localparam int SAT_MAX = sat_max(DEF_DATA_W);
    localparam int SAT_MIN = sat_min(DEF_DATA_W);

endpackage

// File: rtl/feeder_fifo.sv
// Synchronous FIFO with a registered first-word-fall-through head.
// The head register is part of the occupancy: level counts every entry
// not yet popped, including the one currently presented on head.
module feeder_fifo
    import fir_feeder_pkg::*;
#(
    parameter int WIDTH = 20,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [WIDTH-1:0]        push_data,
    input  logic                    pop,
    output logic                    full,
    output logic                    empty,
    output logic [clog2(DEPTH):0]   level,
    output logic [WIDTH-1:0]        head
);

    localparam int PW    = clog2(DEPTH);
    localparam int CNT_W = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0] level_c;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             do_push;
    logic             do_pop;

    // Pointer/count update, storage write and next head selection.
    always_comb begin
        level_c = wr_cnt_q - rd_cnt_q;
        full    = (level_c == CNT_W'(DEPTH));
        do_pop  = pop & out_valid_q;
        // A pop frees a slot in the same cycle, so a push while full is
        // still taken when the head is being consumed.
        do_push = push & (~full | do_pop);

        wr_cnt_d = wr_cnt_q;
        if (do_push) begin
            wr_cnt_d = wr_cnt_q + CNT_W'(1);
        end
        rd_cnt_d = rd_cnt_q;
        if (do_pop) begin
            rd_cnt_d = rd_cnt_q + CNT_W'(1);
        end

        mem_d = mem_q;
        if (do_push) begin
            mem_d[wr_cnt_q[PW-1:0]] = push_data;
        end

        out_valid_d = (wr_cnt_d != rd_cnt_d);
        out_data_d  = out_data_q;
        if (out_valid_d) begin
            // The pushed word becomes the head when nothing older remains;
            // bypass it so it appears one cycle after the push.
            if (do_push && (rd_cnt_d == wr_cnt_q)) begin
                out_data_d = push_data;
            end else begin
                out_data_d = mem_q[rd_cnt_d[PW-1:0]];
            end
        end
    end

    // Counters and head register; all cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // Storage array; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign empty = ~out_valid_q;
    assign level = level_c;
    assign head  = out_data_q;

endmodule

// File: rtl/fir_sample_feeder.sv
// Upstream stage of the per-channel ADC FIR filter. Turns each rising edge
// of the ADC sample strobe into one {channel, sample} FIFO entry and
// presents the FIFO head as an AXI-Stream master.
// Optional build macro FEEDER_OFFSET_EN adds a per-channel offset table;
// samples are then offset-corrected, saturated to signed DATA_W and
// delayed by one extra register stage.
module fir_sample_feeder
    import fir_feeder_pkg::*;
#(
    parameter int NUM_CHAN   = DEF_NUM_CHAN,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int OVF_W      = DEF_OVF_W
) (
`ifdef FEEDER_OFFSET_EN
    input  logic                        ofs_wr,
    input  logic [clog2(NUM_CHAN)-1:0]  ofs_chan,
    input  logic [DATA_W-1:0]           ofs_data,
`endif
    input  logic                        sysclk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        adc_valid,
    input  logic [clog2(NUM_CHAN)-1:0]  adc_chan,
    input  logic [DATA_W-1:0]           adc_data,
    output logic                        m_tvalid,
    input  logic                        m_tready,
    output logic [DATA_W-1:0]           m_tdata,
    output logic [clog2(NUM_CHAN)-1:0]  m_tuser,
    output logic [clog2(FIFO_DEPTH):0]  fifo_level,
    output logic [OVF_W-1:0]            ovf_count,
    input  logic                        ovf_clear
);

    localparam int CW       = clog2(NUM_CHAN);
    localparam int ENTRY_W  = CW + DATA_W;
    localparam int CHAN_LSB = entry_chan_lsb(DATA_W);

    logic               adc_valid_q, adc_valid_d;
    logic               cap_push;
    logic               push;
    logic [ENTRY_W-1:0] push_entry;
    logic               pop;
    logic               drop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] head_entry;
    logic [OVF_W-1:0]   ovf_q, ovf_d;

    // Rising-edge detect on the strobe level; one capture per conversion.
    always_comb begin
        adc_valid_d = adc_valid;
        cap_push    = enable & adc_valid & ~adc_valid_q;
    end

    // Strobe history resets high so a strobe already high at reset release
    // is not mistaken for a new conversion.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            adc_valid_q <= 1'b1;
        end else begin
            adc_valid_q <= adc_valid_d;
        end
    end

`ifdef FEEDER_OFFSET_EN
    localparam logic signed [DATA_W:0] SMAX_V = (DATA_W + 1)'(sat_max(DATA_W));
    localparam logic signed [DATA_W:0] SMIN_V = (DATA_W + 1)'(sat_min(DATA_W));

    logic [DATA_W-1:0]      ofs_tab_q [NUM_CHAN];
    logic [DATA_W-1:0]      ofs_tab_d [NUM_CHAN];
    logic signed [DATA_W:0] diff;
    logic [DATA_W-1:0]      sat_val;
    logic                   pipe_valid_q, pipe_valid_d;
    logic [ENTRY_W-1:0]     pipe_entry_q, pipe_entry_d;

    // Offset table write; captures see the new value from the next cycle.
    always_comb begin
        ofs_tab_d = ofs_tab_q;
        if (ofs_wr) begin
            ofs_tab_d[ofs_chan] = ofs_data;
        end
    end

    // Subtract the channel offset with one spare bit so the full unsigned
    // range cannot wrap, then clamp into the signed DATA_W range.
    always_comb begin
        diff = $signed({1'b0, adc_data}) - $signed({1'b0, ofs_tab_q[adc_chan]});
        if (diff > SMAX_V) begin
            sat_val = SMAX_V[DATA_W-1:0];
        end else if (diff < SMIN_V) begin
            sat_val = SMIN_V[DATA_W-1:0];
        end else begin
            sat_val = diff[DATA_W-1:0];
        end
        pipe_valid_d = cap_push;
        pipe_entry_d = pipe_entry_q;
        if (cap_push) begin
            pipe_entry_d = {adc_chan, sat_val};
        end
    end

    // Offset table and corrected-sample pipeline register.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CHAN; i++) begin
                ofs_tab_q[i] <= '0;
            end
            pipe_valid_q <= 1'b0;
            pipe_entry_q <= '0;
        end else begin
            ofs_tab_q    <= ofs_tab_d;
            pipe_valid_q <= pipe_valid_d;
            pipe_entry_q <= pipe_entry_d;
        end
    end

    // The FIFO is fed from the pipeline register.
    always_comb begin
        push       = pipe_valid_q;
        push_entry = pipe_entry_q;
    end
`else
    // The FIFO is fed directly with the raw captured sample.
    always_comb begin
        push       = cap_push;
        push_entry = {adc_chan, adc_data};
    end
`endif

    feeder_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (sysclk),
        .rst       (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level),
        .head      (head_entry)
    );

    // Handshake, drop detection and saturating overflow count; a clear in
    // the same cycle as a drop leaves exactly that one drop counted.
    always_comb begin
        pop   = ~fifo_empty & m_tready;
        drop  = push & fifo_full & ~pop;
        ovf_d = ovf_q;
        if (ovf_clear) begin
            ovf_d = drop ? OVF_W'(1) : '0;
        end else if (drop && (ovf_q != {OVF_W{1'b1}})) begin
            ovf_d = ovf_q + OVF_W'(1);
        end
    end

    // Overflow counter register.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    // Valid/ready: m_tvalid rises only from the registered FIFO head and
    // falls only after a cycle with m_tvalid & m_tready (or on reset);
    // m_tdata/m_tuser are stable while m_tvalid waits for m_tready.
    assign m_tvalid  = ~fifo_empty;
    assign m_tdata   = head_entry[ENTRY_DATA_LSB +: DATA_W];
    assign m_tuser   = head_entry[CHAN_LSB +: CW];
    assign ovf_count = ovf_q;

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Self-checking bench for fir_sample_feeder: directed scenarios followed by
// random traffic, all checked against a queue-based reference model.
module tb_fir_sample_feeder;
  import fir_feeder_pkg::*;

  localparam int DW      = DEF_DATA_W;
  localparam int CW      = CH_W;
  localparam int DEPTH   = DEF_FIFO_DEPTH;
  localparam int LW      = clog2(DEF_FIFO_DEPTH) + 1;
  localparam int OW      = DEF_OVF_W;
  localparam int EW      = CW + DW;
  localparam int OVF_MAX = (1 << OW) - 1;
`ifdef FEEDER_OFFSET_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  // ---------------- clock / reset / signals ----------------
  logic          sysclk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          adc_valid = 1'b0;
  logic [CW-1:0] adc_chan = '0;
  logic [DW-1:0] adc_data = '0;
  logic          m_tready = 1'b0;
  logic          ovf_clear = 1'b0;
  logic          m_tvalid;
  logic [DW-1:0] m_tdata;
  logic [CW-1:0] m_tuser;
  logic [LW-1:0] fifo_level;
  logic [OW-1:0] ovf_count;
`ifdef FEEDER_OFFSET_EN
  logic          ofs_wr = 1'b0;
  logic [CW-1:0] ofs_chan = '0;
  logic [DW-1:0] ofs_data = '0;
`endif

  always #5 sysclk = ~sysclk;

  fir_sample_feeder dut (
`ifdef FEEDER_OFFSET_EN
    .ofs_wr     (ofs_wr),
    .ofs_chan   (ofs_chan),
    .ofs_data   (ofs_data),
`endif
    .sysclk     (sysclk),
    .reset      (reset),
    .enable     (enable),
    .adc_valid  (adc_valid),
    .adc_chan   (adc_chan),
    .adc_data   (adc_data),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tdata    (m_tdata),
    .m_tuser    (m_tuser),
    .fifo_level (fifo_level),
    .ovf_count  (ovf_count),
    .ovf_clear  (ovf_clear)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  int xfer_cnt = 0;
  logic [DW-1:0] last_data = '0;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int  m_level = 0;
  int  m_ovf = 0;
  bit  m_prev = 1'b1;
`ifdef FEEDER_OFFSET_EN
  logic [DW-1:0] m_ofs[DEF_NUM_CHAN];
  bit            pend_v = 1'b0;
  logic [EW-1:0] pend_d = '0;

  function automatic logic [DW-1:0] ofs_apply(input logic [DW-1:0] d, input logic [DW-1:0] o);
    int v;
    v = int'(d) - int'(o);
    if (v > SAT_MAX) v = SAT_MAX;
    if (v < SAT_MIN) v = SAT_MIN;
    return DW'(v);
  endfunction
`endif

  // Model: occupancy count plus expected-data queue, updated at each edge.
  always @(posedge sysclk) begin : model
    bit pop_v, rise, drop, push_v;
    logic [EW-1:0] push_d;
    if (reset) begin
      m_level = 0;
      m_ovf   = 0;
      m_prev  = 1'b1;
      exp_q.delete();
`ifdef FEEDER_OFFSET_EN
      pend_v = 1'b0;
      for (int i = 0; i < DEF_NUM_CHAN; i++) m_ofs[i] = '0;
`endif
    end else begin
      pop_v  = (m_level != 0) && m_tready;
      rise   = enable && adc_valid && !m_prev;
      m_prev = adc_valid;
`ifdef FEEDER_OFFSET_EN
      push_v = pend_v;
      push_d = pend_d;
      pend_v = rise;
      pend_d = {adc_chan, ofs_apply(adc_data, m_ofs[adc_chan])};
      if (ofs_wr) m_ofs[ofs_chan] = ofs_data;
`else
      push_v = rise;
      push_d = {adc_chan, adc_data};
`endif
      if (pop_v) m_level--;
      drop = 1'b0;
      if (push_v) begin
        if (m_level < DEPTH) begin
          m_level++;
          exp_q.push_back(push_d);
        end else begin
          drop = 1'b1;
        end
      end
      if (ovf_clear) m_ovf = drop ? 1 : 0;
      else if (drop && m_ovf < OVF_MAX) m_ovf++;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge sysclk) begin : monitor
    logic [EW-1:0] e;
    check("m_tvalid", m_tvalid, m_level != 0);
    check("fifo_level", fifo_level, m_level);
    check("ovf_count", ovf_count, m_ovf);
    if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_xfer: got tuser=%0d tdata=0x%0h expected no transfer", m_tuser, m_tdata);
      end else begin
        e = exp_q.pop_front();
        check("xfer_data", {m_tuser, m_tdata}, e);
      end
      xfer_cnt++;
      last_data = m_tdata;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n = 1);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic strobe(input logic [CW-1:0] ch, input logic [DW-1:0] d);
    adc_chan  = ch;
    adc_data  = d;
    adc_valid = 1'b1;
    cyc(1);
    adc_valid = 1'b0;
    cyc(1);
  endtask

`ifdef FEEDER_OFFSET_EN
  task automatic set_ofs(input logic [CW-1:0] ch, input logic [DW-1:0] v);
    ofs_chan = ch;
    ofs_data = v;
    ofs_wr   = 1'b1;
    cyc(1);
    ofs_wr   = 1'b0;
  endtask
`endif

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    int x0;
    cyc(2);
    reset    = 1'b0;
    enable   = 1'b1;
    m_tready = 1'b1;
    cyc(1);

    // 1: single strobe held 5 cycles, latency and exactly one transfer
    x0 = xfer_cnt;
    adc_chan  = 2;
    adc_data  = 16'h1234;
    adc_valid = 1'b1;
    cyc(1);
    @(negedge sysclk);
    check("t1_latency_n1", m_tvalid, LAT == 1);
    cyc(1);
    @(negedge sysclk);
    check("t1_latency_n2", m_tvalid, LAT == 2);
    cyc(3);
    adc_valid = 1'b0;
    cyc(4);
    check("t1_one_xfer", xfer_cnt - x0, 1);

    // 2: stalled sink, 6 strobes into a 4-deep FIFO
    m_tready = 1'b0;
    for (int i = 0; i < 6; i++) strobe(CW'(i), DW'(16'h0A00 + i));
    @(negedge sysclk);
    check("t2_level_full", fifo_level, DEPTH);
    check("t2_ovf", ovf_count, 2);
    cyc(1);
    x0 = xfer_cnt;
    m_tready = 1'b1;
    cyc(5);
    check("t2_drain_xfers", xfer_cnt - x0, 4);

    // 3: full FIFO, strobe edge and pop land in the same cycle
    m_tready = 1'b0;
    for (int i = 0; i < 4; i++) strobe(CW'(i), DW'(16'h0B00 + i));
    adc_chan  = 3;
    adc_data  = 16'h0BFF;
    adc_valid = 1'b1;
`ifdef FEEDER_OFFSET_EN
    cyc(1);
`endif
    m_tready = 1'b1;
    cyc(1);
    m_tready  = 1'b0;
    adc_valid = 1'b0;
    @(negedge sysclk);
    check("t3_level", fifo_level, DEPTH);
    check("t3_ovf", ovf_count, 2);
    cyc(1);
    m_tready = 1'b1;
    cyc(6);

    // 4: enable=0 ignores strobes, queued samples still drain
    ovf_clear = 1'b1;
    cyc(1);
    ovf_clear = 1'b0;
    m_tready  = 1'b0;
    for (int i = 0; i < 3; i++) strobe(CW'(i), DW'(16'h0C00 + i));
    cyc(2);
    enable = 1'b0;
    strobe(1, 16'h0CCC);
    strobe(2, 16'h0CCD);
    x0 = xfer_cnt;
    m_tready = 1'b1;
    cyc(6);
    check("t4_xfers", xfer_cnt - x0, 3);
    check("t4_ovf", ovf_count, 0);
    enable = 1'b1;
    // strobe already high when reset releases
    m_tready  = 1'b0;
    adc_valid = 1'b1;
    reset     = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(4);
    adc_valid = 1'b0;
    @(negedge sysclk);
    check("t4_no_push_at_release", fifo_level, 0);

    // 5: reset mid-stream discards queue, then overflow saturation
    cyc(1);
    strobe(0, 16'h0D00);
    strobe(1, 16'h0D01);
    cyc(2);
    @(negedge sysclk);
    check("t5_valid_before_reset", m_tvalid, 1);
    cyc(1);
    reset = 1'b1;
    cyc(1);
    @(negedge sysclk);
    check("t5_valid_after_reset", m_tvalid, 0);
    check("t5_level_after_reset", fifo_level, 0);
    reset = 1'b0;
    cyc(1);
    for (int i = 0; i < 4; i++) strobe(CW'(i), DW'($urandom));
    for (int i = 0; i < 256; i++) strobe(CW'(i), DW'($urandom));
    @(negedge sysclk);
    check("t5_ovf_sat", ovf_count, OVF_MAX);
    cyc(1);
    strobe(2, 16'h0DDD);
    @(negedge sysclk);
    check("t5_ovf_stays", ovf_count, OVF_MAX);
    cyc(1);
    adc_valid = 1'b1;
`ifdef FEEDER_OFFSET_EN
    cyc(1);
`endif
    ovf_clear = 1'b1;
    cyc(1);
    ovf_clear = 1'b0;
    adc_valid = 1'b0;
    cyc(2);
    @(negedge sysclk);
    check("t5_clear_with_drop", ovf_count, 1);
    cyc(1);
    ovf_clear = 1'b1;
    cyc(1);
    ovf_clear = 1'b0;
    @(negedge sysclk);
    check("t5_clear", ovf_count, 0);
    cyc(1);
    m_tready = 1'b1;
    cyc(6);

`ifdef FEEDER_OFFSET_EN
    // 6: offset correction and saturation
    set_ofs(1, 16'h8000);
    strobe(1, 16'h0000);
    cyc(2);
    check("t6_neg_full", last_data, 16'h8000);
    strobe(1, 16'hFFFF);
    cyc(2);
    check("t6_pos_max", last_data, 16'h7FFF);
    set_ofs(0, 16'h7FFF);
    strobe(0, 16'h0000);
    cyc(2);
    check("t6_no_sat", last_data, 16'h8001);
    set_ofs(0, 16'hFFFF);
    strobe(0, 16'h0000);
    cyc(2);
    check("t6_sat_min", last_data, 16'h8000);
    strobe(2, 16'h0123);
    cyc(2);
    check("t6_zero_offset", last_data, 16'h0123);
`endif

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      adc_valid = ($urandom_range(0, 1) == 1);
      adc_chan  = CW'($urandom);
      adc_data  = DW'($urandom);
      enable    = ($urandom_range(0, 9) != 0);
      m_tready  = ($urandom_range(0, 3) != 0);
      ovf_clear = ($urandom_range(0, 49) == 0);
      reset     = ($urandom_range(0, 299) == 0);
`ifdef FEEDER_OFFSET_EN
      ofs_wr   = ($urandom_range(0, 7) == 0);
      ofs_chan = CW'($urandom);
      ofs_data = DW'($urandom);
`endif
      cyc(1);
    end
    adc_valid = 1'b0;
    enable    = 1'b1;
    m_tready  = 1'b1;
    ovf_clear = 1'b0;
    reset     = 1'b0;
`ifdef FEEDER_OFFSET_EN
    ofs_wr = 1'b0;
`endif
    cyc(12);
    @(negedge sysclk);
    check("drain_exp_empty", exp_q.size(), 0);
    check("drain_level", fifo_level, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
